// File: rtl/cache_sdpb_alu54.sv
// Simple dual-port RAM (16 x 16-bit write side, 8 x 32-bit read side) with an optional
// output register, alongside an independent registered 21-bit adder with a cascade output.
module cache_sdpb_alu54 #(
  parameter int READ_MODE = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cea,
  input  logic [3:0]  ada,
  input  logic [15:0] din,
  input  logic        ceb,
  input  logic        resetb,
  input  logic        oce,
  input  logic [2:0]  adb,
  output logic [31:0] dout,
  input  logic [20:0] a,
  input  logic [20:0] b,
  input  logic        ce,
  input  logic        reset,
  output logic [21:0] sum,
  output logic [54:0] caso
);

  logic [15:0] mem_q [16];
  logic [31:0] rd_q, rd_d;
  logic [21:0] sum_q, sum_d;

  // Cells are never reset; contents are undefined until written.
  always_ff @(posedge clk) begin
    if (cea) mem_q[ada] <= din;
  end

  // Nonblocking memory update makes a same-edge read return the old contents.
  always_comb begin
    rd_d = rd_q;
    if (resetb)   rd_d = '0;
    else if (ceb) rd_d = {mem_q[{adb, 1'b1}], mem_q[{adb, 1'b0}]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_q <= '0;
    else          rd_q <= rd_d;
  end

  generate
    if (READ_MODE == 1) begin : gen_pipelined
      logic [31:0] out_q, out_d;

      always_comb begin
        out_d = out_q;
        if (resetb)   out_d = '0;
        else if (oce) out_d = rd_q;
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) out_q <= '0;
        else          out_q <= out_d;
      end

      assign dout = out_q;
    end else begin : gen_bypass
      logic oce_unused;
      assign oce_unused = oce;
      assign dout       = rd_q;
    end
  endgenerate

  // Operands widened by one bit so the carry lands in sum[21].
  always_comb begin
    sum_d = sum_q;
    if (reset)   sum_d = '0;
    else if (ce) sum_d = {1'b0, a} + {1'b0, b};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sum_q <= '0;
    else          sum_q <= sum_d;
  end

  assign sum  = sum_q;
  assign caso = {33'd0, sum_q};

endmodule

// File: tb/tb_cache_sdpb_alu54.sv
// Bench for cache_sdpb_alu54: bypass and pipelined instances driven in parallel,
// checked by a vector table, directed reset/sweep sequences and a random run vs a model.
module tb_cache_sdpb_alu54;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cea, ceb, resetb, oce, ce, reset;
  logic [3:0]  ada;
  logic [15:0] din;
  logic [2:0]  adb;
  logic [20:0] a, b;
  logic [31:0] dout0, dout1;
  logic [21:0] sum0, sum1;
  logic [54:0] caso0, caso1;

  always #5 clk = ~clk;

  cache_sdpb_alu54 #(.READ_MODE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .cea(cea), .ada(ada), .din(din), .ceb(ceb),
    .resetb(resetb), .oce(oce), .adb(adb), .dout(dout0), .a(a), .b(b), .ce(ce),
    .reset(reset), .sum(sum0), .caso(caso0)
  );

  cache_sdpb_alu54 #(.READ_MODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .cea(cea), .ada(ada), .din(din), .ceb(ceb),
    .resetb(resetb), .oce(oce), .adb(adb), .dout(dout1), .a(a), .b(b), .ce(ce),
    .reset(reset), .sum(sum1), .caso(caso1)
  );

  // Reference model: memory as an array of half-words, words assembled on demand.
  logic [15:0] m_mem [16];
  logic [31:0] m_rd, m_out;
  logic [21:0] m_sum;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        cea;
    logic [3:0]  ada;
    logic [15:0] din;
    logic        ceb;
    logic [2:0]  adb;
    logic        resetb;
    logic        oce;
    logic [20:0] a;
    logic [20:0] b;
    logic        ce;
    logic        reset;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    logic [21:0] e_sum;
  } vec_t;

  vec_t tbl [12];

  function automatic logic [31:0] m_word(input int k);
    return {m_mem[2*k+1], m_mem[2*k]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cea = 0; ada = 0; din = 0; ceb = 0; adb = 0; resetb = 0; oce = 0;
    a = 0; b = 0; ce = 0; reset = 0;
  endtask

  // Advance one clock edge, evolving the model from the inputs seen at that edge.
  task automatic tick();
    logic [31:0] rd_n, out_n;
    logic [21:0] sum_n;
    logic        w_en;
    logic [3:0]  w_adr;
    logic [15:0] w_dat;
    rd_n  = resetb ? 32'd0 : (ceb ? m_word(int'(adb)) : m_rd);
    out_n = resetb ? 32'd0 : (oce ? m_rd : m_out);
    sum_n = reset  ? 22'd0 : (ce ? 22'(longint'(a) + longint'(b)) : m_sum);
    w_en = cea; w_adr = ada; w_dat = din;
    @(posedge clk);
    #1;
    if (w_en) m_mem[w_adr] = w_dat;
    if (!reset_n) begin
      m_rd = '0; m_out = '0; m_sum = '0;
    end else begin
      m_rd = rd_n; m_out = out_n; m_sum = sum_n;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dout0"}, 64'(dout0), 64'(m_rd));
    chk({tag, ".dout1"}, 64'(dout1), 64'(m_out));
    chk({tag, ".sum0"},  64'(sum0),  64'(m_sum));
    chk({tag, ".sum1"},  64'(sum1),  64'(m_sum));
    chk({tag, ".caso0"}, 64'(caso0), 64'({33'd0, m_sum}));
    chk({tag, ".caso1"}, 64'(caso1), 64'({33'd0, m_sum}));
  endtask

  initial begin
    tbl[0]  = '{1'b1, 4'd0, 16'hA0A0, 1'b0, 3'd0, 1'b0, 1'b1, 21'h0,      21'h0,      1'b0, 1'b0, 32'h0,        32'h0,        22'h0};
    tbl[1]  = '{1'b1, 4'd1, 16'hB1B1, 1'b0, 3'd0, 1'b0, 1'b1, 21'h0,      21'h0,      1'b0, 1'b0, 32'h0,        32'h0,        22'h0};
    tbl[2]  = '{1'b0, 4'd0, 16'h0,    1'b1, 3'd0, 1'b0, 1'b1, 21'h1FFFFF, 21'h5,      1'b1, 1'b0, 32'hB1B1A0A0, 32'h0,        22'h200004};
    tbl[3]  = '{1'b0, 4'd0, 16'h0,    1'b0, 3'd0, 1'b0, 1'b0, 21'h3,      21'h4,      1'b0, 1'b0, 32'hB1B1A0A0, 32'h0,        22'h200004};
    tbl[4]  = '{1'b0, 4'd0, 16'h0,    1'b0, 3'd0, 1'b0, 1'b1, 21'h1,      21'h1,      1'b1, 1'b1, 32'hB1B1A0A0, 32'hB1B1A0A0, 22'h0};
    tbl[5]  = '{1'b1, 4'd2, 16'h0002, 1'b0, 3'd0, 1'b0, 1'b1, 21'h1FFFFF, 21'h1FFFFF, 1'b1, 1'b0, 32'hB1B1A0A0, 32'hB1B1A0A0, 22'h3FFFFE};
    tbl[6]  = '{1'b1, 4'd3, 16'h0003, 1'b0, 3'd0, 1'b0, 1'b1, 21'h0,      21'h0,      1'b0, 1'b0, 32'hB1B1A0A0, 32'hB1B1A0A0, 22'h3FFFFE};
    tbl[7]  = '{1'b1, 4'd2, 16'hFFFF, 1'b1, 3'd1, 1'b0, 1'b1, 21'h0,      21'h0,      1'b0, 1'b0, 32'h00030002, 32'hB1B1A0A0, 22'h3FFFFE};
    tbl[8]  = '{1'b0, 4'd0, 16'h0,    1'b1, 3'd1, 1'b0, 1'b1, 21'h0,      21'h0,      1'b0, 1'b0, 32'h0003FFFF, 32'h00030002, 22'h3FFFFE};
    tbl[9]  = '{1'b0, 4'd0, 16'h0,    1'b1, 3'd0, 1'b1, 1'b1, 21'h0,      21'h0,      1'b0, 1'b0, 32'h0,        32'h0,        22'h3FFFFE};
    tbl[10] = '{1'b0, 4'd0, 16'h0,    1'b1, 3'd0, 1'b0, 1'b1, 21'h0,      21'h0,      1'b0, 1'b0, 32'hB1B1A0A0, 32'h0,        22'h3FFFFE};
    tbl[11] = '{1'b0, 4'd0, 16'h1234, 1'b1, 3'd0, 1'b0, 1'b1, 21'h0,      21'h0,      1'b0, 1'b0, 32'hB1B1A0A0, 32'hB1B1A0A0, 22'h3FFFFE};

    // Reset asserted from time zero with arbitrary inputs: outputs must be 0 before any edge.
    reset_n = 1'b0;
    cea = 1; ada = 4'd5; din = 16'hDEAD; ceb = 1; adb = 3'd2; resetb = 0; oce = 1;
    a = 21'h12345; b = 21'h54321; ce = 1; reset = 0;
    m_rd = '0; m_out = '0; m_sum = '0;
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    #3;
    chk("por.dout0", 64'(dout0), 64'd0);
    chk("por.dout1", 64'(dout1), 64'd0);
    chk("por.sum0",  64'(sum0),  64'd0);
    chk("por.caso0", 64'(caso0), 64'd0);
    $display("reset at t=0: dout0=%h dout1=%h sum=%h", dout0, dout1, sum0);
    idle_inputs();
    #19;
    reset_n = 1'b1;

    // Table-driven directed vectors.
    for (int i = 0; i < 12; i++) begin
      cea = tbl[i].cea; ada = tbl[i].ada; din = tbl[i].din; ceb = tbl[i].ceb;
      adb = tbl[i].adb; resetb = tbl[i].resetb; oce = tbl[i].oce;
      a = tbl[i].a; b = tbl[i].b; ce = tbl[i].ce; reset = tbl[i].reset;
      tick();
      chk($sformatf("vec%0d.dout0", i), 64'(dout0), 64'(tbl[i].e_d0));
      chk($sformatf("vec%0d.dout1", i), 64'(dout1), 64'(tbl[i].e_d1));
      chk($sformatf("vec%0d.sum",   i), 64'(sum0),  64'(tbl[i].e_sum));
      chk($sformatf("vec%0d.caso",  i), 64'(caso0), 64'({33'd0, tbl[i].e_sum}));
      $display("vec %0d: dout0=%h dout1=%h sum=%h", i, dout0, dout1, sum0);
    end

    // Asynchronous reset mid-cycle aborts activity; no edge needed.
    idle_inputs();
    ce = 1; a = 21'd10; b = 21'd20; ceb = 1; adb = 3'd0; oce = 1;
    #2;
    reset_n = 1'b0;
    m_rd = '0; m_out = '0; m_sum = '0;
    #1;
    chk("arst.dout0", 64'(dout0), 64'd0);
    chk("arst.dout1", 64'(dout1), 64'd0);
    chk("arst.sum0",  64'(sum0),  64'd0);
    chk("arst.caso0", 64'(caso0), 64'd0);
    $display("async reset mid-cycle: dout0=%h sum=%h", dout0, sum0);
    tick();
    check_all("arst_hold");
    reset_n = 1'b1;
    idle_inputs();
    tick();
    check_all("post_rel_idle");
    ce = 1; a = 21'd10; b = 21'd20; ceb = 1; adb = 3'd0;
    tick();
    chk("post_rel.dout0", 64'(dout0), 64'h0000_0000_B1B1_A0A0);
    chk("post_rel.sum0",  64'(sum0),  64'd30);
    check_all("post_rel");
    $display("first edge after release: dout0=%h sum=%h", dout0, sum0);

    // Full sweep: write every cell, read every word.
    idle_inputs();
    oce = 1;
    for (int i = 0; i < 16; i++) begin
      cea = 1; ada = 4'(i); din = 16'(16'h1000 + i);
      tick();
      $display("sweep write cell %0d = %h", i, din);
    end
    cea = 0;
    for (int k = 0; k < 8; k++) begin
      ceb = 1; adb = 3'(k);
      tick();
      chk($sformatf("sweep.word%0d", k), 64'(dout0),
          64'({16'(16'h1000 + 2*k + 1), 16'(16'h1000 + 2*k)}));
      check_all($sformatf("sweep%0d", k));
      $display("sweep read word %0d = %h", k, dout0);
    end
    chk("sweep.word7_const", 64'(dout0), 64'h0000_0000_100F_100E);

    // Randomized traffic against the model.
    for (int n = 0; n < 200; n++) begin
      cea = 1'($urandom_range(0, 1)); ada = 4'($urandom); din = 16'($urandom);
      ceb = 1'($urandom_range(0, 1)); adb = 3'($urandom);
      resetb = ($urandom_range(0, 15) == 0); oce = 1'($urandom_range(0, 1));
      a = 21'($urandom); b = 21'($urandom);
      ce = 1'($urandom_range(0, 1)); reset = ($urandom_range(0, 15) == 0);
      tick();
      check_all($sformatf("rnd%0d", n));
      $display("rnd %0d: dout0=%h dout1=%h sum=%h", n, dout0, dout1, sum0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_sdpb_alu54.md
CACHE_SDPB_ALU54 -- requirements
Module: cache_sdpb_alu54

Interface
REQ-001 The block SHALL expose the parameters below, one per line (name, default, meaning).
REQ-002 READ_MODE, 0, 0 = bypass (1-cycle read latency); 1 = pipelined (extra output register gated by oce).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low (clk, reset_n).
REQ-004 The ports SHALL be as below, one per line (name direction width meaning).
- clk  in  1  single clock; all registers on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cea  in  1  write enable, RAM port A.
- ada  in  4  half-word write address, 0..15.
- din  in  16  write data.
- ceb  in  1  read enable, RAM port B.
- resetb  in  1  synchronous active-high clear of read output registers.
- oce  in  1  output-register enable; used only when READ_MODE=1.
- adb  in  3  32-bit word read address, 0..7.
- dout  out  32  read data.
- a  in  21  adder operand A.
- b  in  21  adder operand B, zero-extended by the caller.
- ce  in  1  adder clock enable.
- reset  in  1  synchronous active-high clear of adder registers.
- sum  out  22  registered A+B.
- caso  out  55  cascade output; sum zero-extended to 55 bits.

Function
REQ-005 Storage SHALL be 16 x 16-bit cells, written at port A and read as 8 x 32-bit words at port B.
REQ-006 When cea=1 at a clock edge, cell[ada] SHALL take din; when cea=0, no cell changes.
REQ-007 Read word k SHALL be {cell[2k+1], cell[2k]}: lower address in bits [15:0], higher address in bits [31:16].
REQ-008 READ_MODE=0: when ceb=1 at edge N, dout SHALL show word[adb] after edge N; when ceb=0, dout SHALL hold.
REQ-009 READ_MODE=0: oce SHALL have no effect.
REQ-010 READ_MODE=1: the read stage SHALL behave as in REQ-008; dout SHALL load the read-stage value on an edge with oce=1 and hold otherwise, giving 2-cycle latency.
REQ-011 Read-during-write: if ceb=1, cea=1 and ada[3:1]==adb at the same edge, the read SHALL return pre-write contents (read-first); the write still completes.
REQ-012 resetb=1 at an edge SHALL clear the read-stage and output registers to 0; it SHALL take priority over ceb and oce and SHALL NOT alter memory cells.
REQ-013 When ce=1 at an edge, sum SHALL load a+b as an unsigned 22-bit value with the carry in bit 21 and no wrap; when ce=0, sum SHALL hold.
REQ-014 Adder latency SHALL be one cycle from operands to sum.
REQ-015 reset=1 at an edge SHALL clear sum to 0, with priority over ce.
REQ-016 caso SHALL always equal {33'd0, sum}.
REQ-017 The RAM path and the adder path SHALL be fully independent; simultaneous activity on both SHALL not interact.
REQ-018 Undriven address bits or X on ada or adb with cea or ceb low SHALL NOT corrupt state.

Reset
REQ-019 reset_n low SHALL asynchronously force dout, the internal read registers, sum and caso to 0.
REQ-020 reset_n SHALL NOT initialise memory cells; their contents after power-up are undefined until written.
REQ-021 After reset_n rises, the first edge SHALL operate normally with no extra delay.
REQ-022 reset_n asserted mid-read or mid-add SHALL abort the operation; outputs stay 0 until the next enabled edge after release.

Verification
REQ-023 Reset: reset_n=0 with any inputs -> dout=0, sum=0, caso=0 immediately (no clock edge needed).
REQ-024 Write/read: write ada=0 din=16'hA0A0 and ada=1 din=16'hB1B1, then ceb=1 adb=0 -> dout=32'hB1B1A0A0 one cycle later; with ceb=0 on the next cycle dout holds.
REQ-025 Full sweep: write cell i = 16'h1000+i for i=0..15, read adb=0..7 -> word k = {16'h1000+2k+1, 16'h1000+2k}; e.g. adb=7 -> 32'h100F100E.
REQ-026 Collision: cell2=16'h0002, cell3=16'h0003; then at one edge cea=1 ada=2 din=16'hFFFF with ceb=1 adb=1 -> dout=32'h00030002; re-reading adb=1 -> dout=32'h0003FFFF.
REQ-027 Adder: a=21'h1FFFFF, b=21'h5, ce=1 -> sum=22'h200004 next cycle, caso=55'h200004; then ce=0 with new operands -> sum holds; reset=1 -> sum=0.
REQ-028 READ_MODE=1: same write as REQ-024, read with oce=1 -> dout=32'hB1B1A0A0 two cycles after the read edge; with oce=0, dout stays 0.
